// File: rtl/spi_tx_module_if.sv
// Bus-side bundle of the SPI transmit engine: request/data in, pin-level
// outputs and strobes out, plus the FSM state for observation.
interface spi_tx_module_if;
    // Handshake: En is a request that is only honoured while State is IDLE;
    // there is no ready back-pressure, so a caller holds or re-issues En
    // until Busy_Sig rises, and Done_Sig marks completion of the byte.
    logic       En;
    logic [7:0] Tx_Data;
    logic       SCLK;
    logic       MOSI;
    logic       L2H_Sig;
    logic       H2L_Sig;
    logic       Busy_Sig;
    logic       Done_Sig;
    logic [1:0] State;

    modport master (
        output En, Tx_Data,
        input  SCLK, MOSI, L2H_Sig, H2L_Sig, Busy_Sig, Done_Sig, State
    );

    modport slave (
        input  En, Tx_Data,
        output SCLK, MOSI, L2H_Sig, H2L_Sig, Busy_Sig, Done_Sig, State
    );
endinterface

// File: rtl/spi_tx_module.sv
// SPI mode-0 master transmitter: 8 bits MSB first, SCLK = CLK/(2*CLK_DIV),
// with one-cycle strobes on every SCLK edge for a lockstep receiver.
module spi_tx_module #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic           CLK,
    input  logic           RSTn,
    spi_tx_module_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q;
    logic [7:0] div_cnt_q;
    logic [4:0] edge_cnt_q;
    logic [6:0] shift_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       l2h_q;
    logic       h2l_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            div_cnt_q  <= 8'd0;
            edge_cnt_q <= 5'd0;
            shift_q    <= 7'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            l2h_q      <= 1'b0;
            h2l_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            l2h_q  <= 1'b0;
            h2l_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.En) begin
                        // Bit 7 goes straight to MOSI; only the remaining bits need shifting.
                        shift_q    <= bus.Tx_Data[6:0];
                        mosi_q     <= bus.Tx_Data[7];
                        busy_q     <= 1'b1;
                        sclk_q     <= 1'b0;
                        div_cnt_q  <= 8'd0;
                        edge_cnt_q <= 5'd0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (edge_cnt_q == 5'd16) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        mosi_q  <= 1'b1;
                        sclk_q  <= 1'b0;
                    end else if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q  <= 8'd0;
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_q + 5'd1;
                        if (!sclk_q) begin
                            l2h_q <= 1'b1;
                        end else begin
                            h2l_q <= 1'b1;
                            // The final falling edge keeps bit 0 on MOSI.
                            if (edge_cnt_q != 5'd15) begin
                                mosi_q  <= shift_q[6];
                                shift_q <= {shift_q[5:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.SCLK     = sclk_q;
    assign bus.MOSI     = mosi_q;
    assign bus.L2H_Sig  = l2h_q;
    assign bus.H2L_Sig  = h2l_q;
    assign bus.Busy_Sig = busy_q;
    assign bus.Done_Sig = done_q;
    assign bus.State    = state_q;
endmodule
